// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: runs one load or store through MAR/MDR/RAM, with alignment, op3 and MFC-timeout traps.
// Latency: req->done is 4 cycles for a store and 5 for a load at the earliest; req is ignored while busy.
module mem_access_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic       Clk,
    input  logic       RESET,
    input  logic       req,
    input  logic [5:0] req_op3,
    input  logic [1:0] addr_lsb,
    input  logic       MFC,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       RAM_enable,
    output logic       MDR_Mux_select,
    output logic [5:0] RAM_OpCode,
    output logic       busy,
    output logic       done,
    output logic       trap,
    output logic [1:0] trap_type
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_MAR,
        S_ISSUE,
        S_WAIT_MFC,
        S_CAPTURE,
        S_DONE,
        S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op3_q, op3_d;
    logic [1:0]  lsb_q, lsb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        mar_q, mar_d;
    logic        mdr_q, mdr_d;
    logic        ram_en_q, ram_en_d;
    logic        mux_q, mux_d;
    logic [5:0]  opc_q, opc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        trap_q, trap_d;
    logic [1:0]  ttype_q, ttype_d;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010,
            6'b000100, 6'b000101, 6'b000110: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic op_store(input logic [5:0] op);
        case (op)
            6'b000100, 6'b000101, 6'b000110: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Byte accesses (LDUB/LDSB/STB) can never be misaligned.
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lsb);
        case (op)
            6'b000000, 6'b000100:             return (lsb != 2'b00);
            6'b000010, 6'b001010, 6'b000110:  return lsb[0];
            default:                          return 1'b0;
        endcase
    endfunction

    // Outputs are registered, so every _d value describes the state being entered.
    always_comb begin
        state_d  = state_q;
        op3_d    = op3_q;
        lsb_d    = lsb_q;
        cnt_d    = cnt_q;
        mar_d    = 1'b0;
        mdr_d    = 1'b0;
        ram_en_d = 1'b0;
        mux_d    = 1'b0;
        opc_d    = 6'b000000;
        done_d   = 1'b0;
        trap_d   = 1'b0;
        ttype_d  = ttype_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op3_d   = req_op3;
                    lsb_d   = addr_lsb;
                    state_d = S_LOAD_MAR;
                    if (op_legal(req_op3) && !misaligned(req_op3, addr_lsb)) begin
                        mar_d = 1'b1;
                        mdr_d = op_store(req_op3);
                    end
                end
            end
            S_LOAD_MAR: begin
                if (!op_legal(op3_q)) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    ttype_d = 2'b10;
                end else if (misaligned(op3_q, lsb_q)) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    ttype_d = 2'b01;
                end else begin
                    state_d  = S_ISSUE;
                    ram_en_d = 1'b1;
                    opc_d    = op3_q;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT_MFC;
                cnt_d    = '0;
                ram_en_d = 1'b1;
                opc_d    = op3_q;
            end
            S_WAIT_MFC: begin
                // A completing MFC beats the timeout on the same cycle.
                if (MFC) begin
                    if (op_store(op3_q)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_CAPTURE;
                        ram_en_d = 1'b1;
                        opc_d    = op3_q;
                        mdr_d    = 1'b1;
                        mux_d    = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    ttype_d = 2'b11;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    ram_en_d = 1'b1;
                    opc_d    = op3_q;
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op3_q    <= 6'b000000;
            lsb_q    <= 2'b00;
            cnt_q    <= '0;
            mar_q    <= 1'b0;
            mdr_q    <= 1'b0;
            ram_en_q <= 1'b0;
            mux_q    <= 1'b0;
            opc_q    <= 6'b000000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            ttype_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            op3_q    <= op3_d;
            lsb_q    <= lsb_d;
            cnt_q    <= cnt_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            ram_en_q <= ram_en_d;
            mux_q    <= mux_d;
            opc_q    <= opc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            trap_q   <= trap_d;
            ttype_q  <= ttype_d;
        end
    end

    assign MAR_Enable     = mar_q;
    assign MDR_Enable     = mdr_q;
    assign RAM_enable     = ram_en_q;
    assign MDR_Mux_select = mux_q;
    assign RAM_OpCode     = opc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign trap           = trap_q;
    assign trap_type      = ttype_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: a table of single accesses plus reset and back-to-back sequences.
module tb_mem_access_sequencer;

    logic       Clk = 1'b0;
    logic       RESET;
    logic       req;
    logic [5:0] req_op3;
    logic [1:0] addr_lsb;
    logic       MFC;
    logic       MAR_Enable, MDR_Enable, RAM_enable, MDR_Mux_select;
    logic [5:0] RAM_OpCode;
    logic       busy, done, trap;
    logic [1:0] trap_type;

    always #5 Clk = ~Clk;

    mem_access_sequencer #(.TIMEOUT(15), .CW(4)) dut (
        .Clk(Clk), .RESET(RESET), .req(req), .req_op3(req_op3), .addr_lsb(addr_lsb), .MFC(MFC),
        .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable), .RAM_enable(RAM_enable),
        .MDR_Mux_select(MDR_Mux_select), .RAM_OpCode(RAM_OpCode), .busy(busy), .done(done),
        .trap(trap), .trap_type(trap_type)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mfc_at: cycle (req cycle = 0) in which MFC is high, 0 = never.
    // early: MFC also high in cycles 1-2, where it must be ignored.
    typedef struct {
        logic [5:0] op3;
        logic [1:0] lsb;
        int         mfc_at;
        bit         early;
        int         e_done;
        int         e_trap;
        int         e_tt;
        int         e_ram;
        int         e_mar;
        int         e_mdr;
        int         e_mux;
    } vec_t;

    vec_t vt[14];

    int r_done, r_trap, r_tt, r_ram, r_mar, r_mdr, r_mux, r_opc_bad, r_both, r_busy_after;

    task automatic run_access(input logic [5:0] op3, input logic [1:0] lsb,
                              input int mfc_at, input bit early);
        bit ended;
        @(negedge Clk);
        req = 1'b1; req_op3 = op3; addr_lsb = lsb; MFC = 1'b0;
        r_done = 0; r_trap = 0; r_tt = 0; r_ram = 0; r_mar = 0; r_mdr = 0;
        r_mux = 0; r_opc_bad = 0; r_both = 0; ended = 1'b0;
        for (int k = 1; k <= 40 && !ended; k++) begin
            @(negedge Clk);
            req = 1'b0;
            if (RAM_enable) begin
                r_ram++;
                if (RAM_OpCode != op3) r_opc_bad++;
            end
            if (MAR_Enable) r_mar++;
            if (MDR_Enable) begin
                r_mdr++;
                r_mux = int'(MDR_Mux_select);
            end
            if (done && trap) r_both++;
            if (done && r_done == 0) r_done = k;
            if (trap && r_trap == 0) begin
                r_trap = k;
                r_tt   = int'(trap_type);
            end
            if (done || trap) ended = 1'b1;
            MFC = (k == mfc_at) || (early && k <= 2);
        end
        if (!ended) chk("access_never_ended", 0, 1);
        @(negedge Clk);
        MFC = 1'b0;
        r_busy_after = int'(busy);
    endtask

    function automatic int outs_flat();
        return int'({MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
                     busy, done, trap, trap_type});
    endfunction

    logic [11:0] busy_pat, done_pat, mar_pat;

    initial begin
        //        op3        lsb    mfc early done trap tt ram mar mdr mux
        vt[0]  = '{6'b000000, 2'b00, 3,  0, 5,  0,  0, 3,  1, 1, 1};  // LD
        vt[1]  = '{6'b000001, 2'b11, 3,  0, 5,  0,  0, 3,  1, 1, 1};  // LDUB odd addr
        vt[2]  = '{6'b000010, 2'b10, 5,  0, 7,  0,  0, 5,  1, 1, 1};  // LDUH, 3 wait cycles
        vt[3]  = '{6'b001010, 2'b01, 3,  0, 0,  2,  1, 0,  0, 0, 0};  // LDSH misaligned
        vt[4]  = '{6'b000100, 2'b00, 3,  0, 4,  0,  0, 2,  1, 1, 0};  // ST
        vt[5]  = '{6'b000110, 2'b01, 3,  0, 0,  2,  1, 0,  0, 0, 0};  // STH misaligned
        vt[6]  = '{6'b111111, 2'b11, 3,  0, 0,  2,  2, 0,  0, 0, 0};  // illegal beats misalign
        vt[7]  = '{6'b000100, 2'b10, 3,  0, 0,  2,  1, 0,  0, 0, 0};  // ST misaligned
        vt[8]  = '{6'b000101, 2'b11, 4,  0, 5,  0,  0, 3,  1, 1, 0};  // STB
        vt[9]  = '{6'b000100, 2'b00, 0,  0, 0,  18, 3, 16, 1, 1, 0};  // ST timeout
        vt[10] = '{6'b001001, 2'b10, 4,  1, 6,  0,  0, 4,  1, 1, 1};  // LDSB, early MFC ignored
        vt[11] = '{6'b000011, 2'b00, 3,  0, 0,  2,  2, 0,  0, 0, 0};  // illegal op3
        vt[12] = '{6'b000000, 2'b01, 3,  0, 0,  2,  1, 0,  0, 0, 0};  // LD misaligned
        vt[13] = '{6'b000000, 2'b00, 17, 0, 19, 0,  0, 17, 1, 1, 1};  // MFC on last wait cycle

        RESET = 1'b1; req = 1'b0; req_op3 = 6'b0; addr_lsb = 2'b0; MFC = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_outputs", outs_flat(), 0);
        RESET = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_access(vt[i].op3, vt[i].lsb, vt[i].mfc_at, vt[i].early);
            chk($sformatf("v%0d_done_cycle", i), r_done, vt[i].e_done);
            chk($sformatf("v%0d_trap_cycle", i), r_trap, vt[i].e_trap);
            chk($sformatf("v%0d_trap_type", i), r_tt, vt[i].e_tt);
            chk($sformatf("v%0d_ram_cycles", i), r_ram, vt[i].e_ram);
            chk($sformatf("v%0d_mar_cycles", i), r_mar, vt[i].e_mar);
            chk($sformatf("v%0d_mdr_cycles", i), r_mdr, vt[i].e_mdr);
            chk($sformatf("v%0d_mdr_mux", i), r_mux, vt[i].e_mux);
            chk($sformatf("v%0d_opcode", i), r_opc_bad, 0);
            chk($sformatf("v%0d_done_and_trap", i), r_both, 0);
            chk($sformatf("v%0d_busy_after", i), r_busy_after, 0);
        end
        chk("trap_type_held", int'(trap_type), 1);

        // Reset while LDUB sits in WAIT_MFC.
        @(negedge Clk);
        req = 1'b1; req_op3 = 6'b000001; addr_lsb = 2'b00;
        @(negedge Clk); req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("wait_ram_enable", int'(RAM_enable), 1);
        chk("wait_busy", int'(busy), 1);
        RESET = 1'b1;
        @(negedge Clk);
        chk("midreset_outputs", outs_flat(), 0);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("post_reset_quiet", int'({done, trap, busy, RAM_enable}), 0);
        end
        run_access(6'b000001, 2'b00, 3, 1'b0);
        chk("after_reset_done_cycle", r_done, 5);
        chk("after_reset_ram_cycles", r_ram, 3);

        // Reset and req on the same edge.
        @(negedge Clk);
        RESET = 1'b1; req = 1'b1; req_op3 = 6'b000000; addr_lsb = 2'b00;
        @(negedge Clk);
        RESET = 1'b0; req = 1'b0;
        chk("reset_vs_req_busy", int'(busy), 0);
        @(negedge Clk);
        chk("reset_vs_req_idle", int'({busy, MAR_Enable}), 0);

        // req held high: STB then LD back to back, MFC held high throughout.
        busy_pat = '0; done_pat = '0; mar_pat = '0;
        @(negedge Clk);
        req = 1'b1; req_op3 = 6'b000101; addr_lsb = 2'b01; MFC = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge Clk);
            busy_pat[k] = busy;
            done_pat[k] = done;
            mar_pat[k]  = MAR_Enable;
            if (k == 1) begin req_op3 = 6'b000000; addr_lsb = 2'b00; end
            if (k == 10) req = 1'b0;
            if (done && trap) chk("b2b_done_and_trap", 1, 0);
        end
        MFC = 1'b0;
        chk("b2b_busy_pattern", int'(busy_pat), int'(12'b0111_1101_1110));
        chk("b2b_done_pattern", int'(done_pat), int'(12'b0100_0001_0000));
        chk("b2b_mar_pattern",  int'(mar_pat),  int'(12'b0000_0100_0010));
        @(negedge Clk);
        chk("b2b_idle_after", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
